// File: rtl/pc_stack_pkg.sv
// Shared definitions for the program-counter / return-stack unit.
// Holds the operation encoding and the default width/depth constants.
package pc_stack_pkg;

  localparam int PC_W_DEFAULT  = 11;
  localparam int DEPTH_DEFAULT = 8;

  // Operation encoding on the op input. Codes 6 and 7 are reserved and
  // behave exactly like OP_HOLD.
  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_INC  = 3'd1,
    OP_SKIP = 3'd2,
    OP_JUMP = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5
  } pc_op_e;

endpackage

// File: rtl/pc_stack_mem.sv
// Circular return-address stack with depth tracking.
// Ports:
//   clk, reset     - clock, synchronous active-high reset (clears all entries)
//   push_i         - write push_data_i at the pointer, advance the pointer
//   pop_i          - retreat the pointer (pop_data_o shows the slot it lands on)
//   push_data_i    - return address to store
//   pop_data_o     - content of the slot just below the pointer
//   depth_o        - number of valid entries, 0..DEPTH (saturating)
//   full_o/empty_o - depth_o == DEPTH / depth_o == 0
// The pointer wraps regardless of depth, so a push when full overwrites the
// oldest entry and a pop when empty still reads a (stale) slot.
module pc_stack_mem
  import pc_stack_pkg::*;
#(
  parameter int PC_W  = PC_W_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [PC_W-1:0]  push_data_i,
  output logic [PC_W-1:0]  pop_data_o,
  output logic [CNT_W-1:0] depth_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PC_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] rd_ptr;

  assign rd_ptr     = ptr_q - PTR_W'(1);
  assign pop_data_o = mem_q[rd_ptr];
  assign depth_o    = cnt_q;
  assign full_o     = (cnt_q == FULL_CNT);
  assign empty_o    = (cnt_q == '0);

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (!full_o) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i) begin
      ptr_d = rd_ptr;
      if (!empty_o) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) mem_q[ptr_q] <= push_data_i;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with hardware return-address stack.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   en          - one-clock instruction advance strobe (q4 phase)
//   op          - HOLD/INC/SKIP/JUMP/CALL/RET (6,7 reserved = HOLD)
//   target      - destination for JUMP and CALL
//   clr_flags   - clears sticky ovf/unf (a same-cycle set wins)
//   counter     - registered program counter
//   depth_used  - valid stack entries, 0..DEPTH
//   ovf, unf    - sticky overflow / underflow flags
// With op tied to INC and en to q4 this sequences exactly like a plain
// incrementing program counter.
module pc_stack_unit
  import pc_stack_pkg::*;
#(
  parameter int PC_W  = PC_W_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [2:0]                 op,
  input  logic [PC_W-1:0]            target,
  input  logic                       clr_flags,
  output logic [PC_W-1:0]            counter,
  output logic [$clog2(DEPTH+1)-1:0] depth_used,
  output logic                       ovf,
  output logic                       unf
);

  logic [PC_W-1:0] counter_q, counter_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic [PC_W-1:0] pc_plus1;
  logic [PC_W-1:0] pop_data;
  logic            push, pop, full, empty;
  pc_op_e          op_e;

  assign op_e     = pc_op_e'(op);
  assign pc_plus1 = counter_q + PC_W'(1);
  assign push     = en && (op_e == OP_CALL);
  assign pop      = en && (op_e == OP_RET);

  pc_stack_mem #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (pc_plus1),
    .pop_data_o  (pop_data),
    .depth_o     (depth_used),
    .full_o      (full),
    .empty_o     (empty)
  );

  always_comb begin
    counter_d = counter_q;
    if (en) begin
      case (op_e)
        OP_INC:  counter_d = pc_plus1;
        OP_SKIP: counter_d = counter_q + PC_W'(2);
        OP_JUMP: counter_d = target;
        OP_CALL: counter_d = target;
        OP_RET:  counter_d = pop_data;
        default: counter_d = counter_q;
      endcase
    end
  end

  // Clear first, then any set event overrides it.
  always_comb begin
    ovf_d = clr_flags ? 1'b0 : ovf_q;
    unf_d = clr_flags ? 1'b0 : unf_q;
    if (push && full)  ovf_d = 1'b1;
    if (pop  && empty) unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      counter_q <= counter_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign counter = counter_q;
  assign ovf     = ovf_q;
  assign unf     = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
module tb_pc_stack_unit;

  localparam int PC_W  = 11;
  localparam int DEPTH = 8;

  localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, SKIP = 3'd2,
                         JUMP = 3'd3, CALL = 3'd4, RET = 3'd5;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            en = 1'b0;
  logic [2:0]      op = 3'd0;
  logic [PC_W-1:0] target = '0;
  logic            clr_flags = 1'b0;
  logic [PC_W-1:0] counter;
  logic [3:0]      depth_used;
  logic            ovf, unf;

  int checks = 0;
  int failures = 0;

  logic [PC_W-1:0] exp_q[$];
  logic [PC_W-1:0] exp_pc;

  pc_stack_unit #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .op         (op),
    .target     (target),
    .clr_flags  (clr_flags),
    .counter    (counter),
    .depth_used (depth_used),
    .ovf        (ovf),
    .unf        (unf)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver: apply one cycle of inputs on the falling edge, sample #1 after rise
  task automatic drive(input logic [2:0] o, input logic [PC_W-1:0] t,
                       input logic e, input logic c, input logic r);
    @(negedge clk);
    op = o; target = t; en = e; clr_flags = c; reset = r;
    @(posedge clk);
    #1;
    en = 1'b0; clr_flags = 1'b0; reset = 1'b0;
  endtask

  task automatic do_reset();
    drive(HOLD, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (counter !== 11'h000 || depth_used !== 4'd0 || ovf !== 1'b0 || unf !== 1'b0) begin
      failures++;
      $display("FAIL reset: counter=%h depth=%0d ovf=%b unf=%b, required 000/0/0/0",
               counter, depth_used, ovf, unf);
    end
  endtask

  task automatic test_inc();
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(PC_W'(i));
      drive(INC, '0, 1'b1, 1'b0, 1'b0);
      exp_pc = exp_q.pop_front();
      checks++;
      if (counter !== exp_pc) begin
        failures++;
        $display("FAIL inc_%0d: counter=%h required %h", i, counter, exp_pc);
      end
    end
    exp_q.push_back(11'h7FF);
    drive(JUMP, 11'h7FF, 1'b1, 1'b0, 1'b0);
    exp_pc = exp_q.pop_front();
    checks++;
    if (counter !== exp_pc) begin
      failures++;
      $display("FAIL jump_7ff: counter=%h required %h", counter, exp_pc);
    end
    exp_q.push_back(11'h000);
    drive(INC, '0, 1'b1, 1'b0, 1'b0);
    exp_pc = exp_q.pop_front();
    checks++;
    if (counter !== exp_pc) begin
      failures++;
      $display("FAIL inc_wrap: counter=%h required %h", counter, exp_pc);
    end
  endtask

  task automatic test_skip();
    logic [2:0]      ops[4] = '{JUMP, SKIP, JUMP, SKIP};
    logic [PC_W-1:0] tgts[4] = '{11'h100, 11'h000, 11'h7FF, 11'h000};
    logic [PC_W-1:0] exps[4] = '{11'h100, 11'h102, 11'h7FF, 11'h001};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(exps[i]);
      drive(ops[i], tgts[i], 1'b1, 1'b0, 1'b0);
      exp_pc = exp_q.pop_front();
      checks++;
      if (counter !== exp_pc) begin
        failures++;
        $display("FAIL skip_step%0d: counter=%h required %h", i, counter, exp_pc);
      end
    end
  endtask

  task automatic test_call_ret();
    drive(JUMP, 11'h010, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(11'h200);
    drive(CALL, 11'h200, 1'b1, 1'b0, 1'b0);
    exp_pc = exp_q.pop_front();
    checks++;
    if (counter !== exp_pc || depth_used !== 4'd1) begin
      failures++;
      $display("FAIL call: counter=%h depth=%0d required %h/1", counter, depth_used, exp_pc);
    end
    exp_q.push_back(11'h011);
    drive(RET, '0, 1'b1, 1'b0, 1'b0);
    exp_pc = exp_q.pop_front();
    checks++;
    if (counter !== exp_pc || depth_used !== 4'd0 || ovf !== 1'b0 || unf !== 1'b0) begin
      failures++;
      $display("FAIL ret: counter=%h depth=%0d ovf=%b unf=%b required %h/0/0/0",
               counter, depth_used, ovf, unf, exp_pc);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    // nine nested calls from 0x000, 0x010, ... 0x080
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(PC_W'((i + 1) * 16));
      drive(CALL, PC_W'((i + 1) * 16), 1'b1, 1'b0, 1'b0);
      exp_pc = exp_q.pop_front();
      checks++;
      if (counter !== exp_pc) begin
        failures++;
        $display("FAIL ovf_call%0d: counter=%h required %h", i, counter, exp_pc);
      end
      if (i == 7) begin
        checks++;
        if (ovf !== 1'b0 || depth_used !== 4'd8) begin
          failures++;
          $display("FAIL ovf_at_full: ovf=%b depth=%0d required 0/8", ovf, depth_used);
        end
      end
    end
    checks++;
    if (ovf !== 1'b1 || depth_used !== 4'd8) begin
      failures++;
      $display("FAIL ovf_flag: ovf=%b depth=%0d required 1/8", ovf, depth_used);
    end
    // sticky: one idle cycle must not clear it
    drive(HOLD, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky: ovf=%b required 1", ovf);
    end
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(PC_W'(11'h081 - k * 16));
      drive(RET, '0, 1'b1, 1'b0, 1'b0);
      exp_pc = exp_q.pop_front();
      checks++;
      if (counter !== exp_pc || depth_used !== 4'(7 - k)) begin
        failures++;
        $display("FAIL ovf_ret%0d: counter=%h depth=%0d required %h/%0d",
                 k, counter, depth_used, exp_pc, 7 - k);
      end
    end
    exp_q.push_back(11'h081);
    drive(RET, '0, 1'b1, 1'b0, 1'b0);
    exp_pc = exp_q.pop_front();
    checks++;
    if (counter !== exp_pc || unf !== 1'b1 || depth_used !== 4'd0) begin
      failures++;
      $display("FAIL ret_underflow_circ: counter=%h unf=%b depth=%0d required %h/1/0",
               counter, unf, depth_used, exp_pc);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    exp_q.push_back(11'h000);
    drive(RET, '0, 1'b1, 1'b0, 1'b0);
    exp_pc = exp_q.pop_front();
    checks++;
    if (counter !== exp_pc || unf !== 1'b1 || depth_used !== 4'd0) begin
      failures++;
      $display("FAIL unf_set: counter=%h unf=%b depth=%0d required %h/1/0",
               counter, unf, depth_used, exp_pc);
    end
    drive(HOLD, '0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (unf !== 1'b0) begin
      failures++;
      $display("FAIL unf_clear: unf=%b required 0", unf);
    end
    drive(RET, '0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (unf !== 1'b1) begin
      failures++;
      $display("FAIL unf_set_wins: unf=%b required 1", unf);
    end
  endtask

  task automatic test_hold();
    logic [2:0] hold_ops[3] = '{HOLD, 3'd6, 3'd7};
    drive(JUMP, 11'h155, 1'b1, 1'b0, 1'b0);
    drive(CALL, 11'h2AA, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(11'h2AA);
      drive(hold_ops[i], 11'h7FF, 1'b1, 1'b0, 1'b0);
      exp_pc = exp_q.pop_front();
      checks++;
      if (counter !== exp_pc || depth_used !== 4'd1) begin
        failures++;
        $display("FAIL hold_op%0d: counter=%h depth=%0d required %h/1",
                 hold_ops[i], counter, depth_used, exp_pc);
      end
    end
    // en low: neither counter nor stack may move
    exp_q.push_back(11'h2AA);
    drive(CALL, 11'h333, 1'b0, 1'b0, 1'b0);
    exp_pc = exp_q.pop_front();
    checks++;
    if (counter !== exp_pc || depth_used !== 4'd1) begin
      failures++;
      $display("FAIL en_low_call: counter=%h depth=%0d required %h/1", counter, depth_used, exp_pc);
    end
    exp_q.push_back(11'h156);
    drive(RET, '0, 1'b1, 1'b0, 1'b0);
    exp_pc = exp_q.pop_front();
    checks++;
    if (counter !== exp_pc) begin
      failures++;
      $display("FAIL hold_ret: counter=%h required %h", counter, exp_pc);
    end
  endtask

  task automatic test_reset_priority();
    drive(JUMP, 11'h123, 1'b1, 1'b0, 1'b0);
    drive(CALL, 11'h300, 1'b1, 1'b0, 1'b0);
    drive(CALL, 11'h310, 1'b1, 1'b0, 1'b0);
    drive(RET, '0, 1'b1, 1'b0, 1'b0);
    drive(RET, '0, 1'b1, 1'b0, 1'b0);
    drive(RET, '0, 1'b1, 1'b0, 1'b0);  // underflow -> unf set
    drive(CALL, 11'h3FF, 1'b1, 1'b1, 1'b1);
    checks++;
    if (counter !== 11'h000 || depth_used !== 4'd0 || ovf !== 1'b0 || unf !== 1'b0) begin
      failures++;
      $display("FAIL reset_prio: counter=%h depth=%0d ovf=%b unf=%b required 000/0/0/0",
               counter, depth_used, ovf, unf);
    end
    exp_q.push_back(11'h000);
    drive(JUMP, 11'h456, 1'b0, 1'b0, 1'b0);
    exp_pc = exp_q.pop_front();
    checks++;
    if (counter !== exp_pc) begin
      failures++;
      $display("FAIL en_low_jump: counter=%h required %h", counter, exp_pc);
    end
    // stack entries were cleared: a RET now reads 0
    exp_q.push_back(11'h000);
    drive(RET, '0, 1'b1, 1'b0, 1'b0);
    exp_pc = exp_q.pop_front();
    checks++;
    if (counter !== exp_pc || unf !== 1'b1) begin
      failures++;
      $display("FAIL reset_clears_stack: counter=%h unf=%b required %h/1", counter, unf, exp_pc);
    end
  endtask

  task automatic test_back_to_back();
    logic [PC_W-1:0] model_pc;
    do_reset();
    model_pc = '0;
    for (int i = 0; i < 20; i++) begin
      logic [PC_W-1:0] t;
      logic [2:0] o;
      t = PC_W'($urandom_range(0, 2047));
      o = ($urandom_range(0, 1) == 0) ? INC : JUMP;
      model_pc = (o == INC) ? model_pc + 11'd1 : t;
      exp_q.push_back(model_pc);
      drive(o, t, 1'b1, 1'b0, 1'b0);
      exp_pc = exp_q.pop_front();
      checks++;
      if (counter !== exp_pc) begin
        failures++;
        $display("FAIL b2b_%0d: counter=%h required %h", i, counter, exp_pc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_skip();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_hold();
    test_reset_priority();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
